// File: rtl/midi_pkg.sv
// Shared types and constants for the MIDI receiver: UART and parser state
// encodings, status-nibble constants and two small helpers.
package midi_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } uart_state_e;

  typedef enum logic [1:0] {
    P_IDLE,
    P_DATA1,
    P_DATA2
  } parser_state_e;

  localparam logic [3:0] STATUS_NOTE_OFF       = 4'h8;
  localparam logic [3:0] STATUS_NOTE_ON        = 4'h9;
  localparam logic [3:0] STATUS_PROG_CHANGE    = 4'hC;
  localparam logic [3:0] STATUS_CHAN_PRESSURE  = 4'hD;
  localparam logic [3:0] STATUS_SYSTEM         = 4'hF;
  localparam logic [7:0] RT_MIN                = 8'hF8;

  // Program Change and Channel Pressure carry a single data byte.
  function automatic logic is_one_data_msg(input logic [7:0] status);
    return (status[7:4] == STATUS_PROG_CHANGE) || (status[7:4] == STATUS_CHAN_PRESSURE);
  endfunction

  // Stretch 7-bit velocity to 8 bits so 127 maps to full scale 0xFF.
  function automatic logic [7:0] vel_to_amp(input logic [6:0] vel);
    return {vel, vel[6]};
  endfunction

endpackage

// File: rtl/midi_rx_parser_if.sv
// Received-byte stream from the UART deserializer to the MIDI parser:
// one-cycle byte strobe with its data, plus a one-cycle framing-error pulse.
interface midi_rx_parser_if;

  logic [7:0] data;
  logic       strobe;
  logic       frame_err;

  modport master (output data, output strobe, output frame_err);
  modport slave  (input  data, input  strobe, input  frame_err);

endinterface

// File: rtl/midi_uart_rx.sv
// 8N1 UART deserializer for the MIDI line: 2-flop synchronizer, start-bit
// glitch rejection at half a bit, centre sampling, byte strobe / frame error.
module midi_uart_rx
  import midi_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 100000000,
  parameter int BAUD        = 31250
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           midi_rx_i,
  midi_rx_parser_if.master rx_bus
);

  localparam int DIV   = CLK_FREQ_HZ / BAUD;
  localparam int HALF  = DIV / 2;
  localparam int CNT_W = $clog2(DIV + 1);
  localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] LAST_HALF = CNT_W'(HALF - 1);

  logic [1:0]       sync_q;
  logic             rx_prev_q;
  logic             rx_s;

  uart_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       data_q, data_d;
  logic             strobe_q, strobe_d;
  logic             ferr_q, ferr_d;

  assign rx_s = sync_q[1];

  // Synchronizer resets to the idle (high) line level so reset release never
  // looks like a start bit on its own.
  // NOTE: every flop is written with <= so all registers update together on the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q    <= 2'b11;
      rx_prev_q <= 1'b1;
    end else begin
      sync_q    <= {sync_q[0], midi_rx_i};
      rx_prev_q <= rx_s;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      data_q   <= '0;
      strobe_q <= 1'b0;
      ferr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      data_q   <= data_d;
      strobe_q <= strobe_d;
      ferr_q   <= ferr_d;
    end
  end

  always_comb begin
    // NOTE: defaults first so no path through the case leaves a signal unassigned (no latches).
    state_d  = state_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    data_d   = data_q;
    strobe_d = 1'b0;
    ferr_d   = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (rx_prev_q && !rx_s) state_d = START;
      end
      START: begin
        if (cnt_q == LAST_HALF) begin
          cnt_d   = '0;
          bit_d   = '0;
          // Line back high at mid start bit: a glitch, not a frame.
          state_d = rx_s ? IDLE : DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DATA: begin
        if (cnt_q == LAST_BIT) begin
          cnt_d   = '0;
          shift_d = {rx_s, shift_q[7:1]};
          if (bit_q == 3'd7) state_d = STOP;
          else               bit_d   = bit_q + 3'd1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      STOP: begin
        if (cnt_q == LAST_BIT) begin
          cnt_d   = '0;
          state_d = IDLE;
          if (rx_s) begin
            strobe_d = 1'b1;
            data_d   = shift_q;
          end else begin
            ferr_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign rx_bus.data      = data_q;
  assign rx_bus.strobe    = strobe_q;
  assign rx_bus.frame_err = ferr_q;

endmodule

// File: rtl/midi_rx_parser.sv
// MIDI receiver: UART front end plus a Note On/Off parser that tracks one held
// note. Define MIDI_RUNNING_STATUS_EN to keep the status byte between messages.
module midi_rx_parser
  import midi_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 100000000,
  parameter int BAUD        = 31250
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       midi_rx,
  input  logic [3:0] channel,
  output logic [7:0] midi_data,
  output logic       midi_valid,
  output logic [7:0] amplitude,
  output logic       frame_err
);

`ifdef MIDI_RUNNING_STATUS_EN
  localparam bit KEEP_STATUS = 1'b1;
`else
  localparam bit KEEP_STATUS = 1'b0;
`endif

  midi_rx_parser_if bus ();

  midi_uart_rx #(
    .CLK_FREQ_HZ (CLK_FREQ_HZ),
    .BAUD        (BAUD)
  ) u_uart (
    .clk       (clk),
    .rst_n     (rst_n),
    .midi_rx_i (midi_rx),
    .rx_bus    (bus)
  );

  parser_state_e pstate_q, pstate_d;
  logic [7:0]    status_q, status_d;
  logic [7:0]    note_q, note_d;
  logic [7:0]    data_q, data_d;
  logic [7:0]    amp_q, amp_d;
  logic          valid_q, valid_d;
  logic          msg_done;
  logic          chan_match;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pstate_q <= P_IDLE;
      status_q <= '0;
      note_q   <= '0;
      data_q   <= '0;
      amp_q    <= '0;
      valid_q  <= 1'b0;
    end else begin
      pstate_q <= pstate_d;
      status_q <= status_d;
      note_q   <= note_d;
      data_q   <= data_d;
      amp_q    <= amp_d;
      valid_q  <= valid_d;
    end
  end

  // Channel is compared live, so a mid-message change applies at completion.
  assign chan_match = (status_q[3:0] == channel);

  always_comb begin
    pstate_d = pstate_q;
    status_d = status_q;
    note_d   = note_q;
    data_d   = data_q;
    amp_d    = amp_q;
    valid_d  = valid_q;
    msg_done = 1'b0;

    if (bus.frame_err) begin
      pstate_d = P_IDLE;
      status_d = '0;
    end else if (bus.strobe && (bus.data < RT_MIN)) begin
      if (bus.data[7:4] == STATUS_SYSTEM) begin
        pstate_d = P_IDLE;
        status_d = '0;
      end else if (bus.data[7]) begin
        pstate_d = P_DATA1;
        status_d = bus.data;
      end else begin
        case (pstate_q)
          P_DATA1: begin
            note_d = bus.data;
            if (is_one_data_msg(status_q)) msg_done = 1'b1;
            else                           pstate_d = P_DATA2;
          end
          P_DATA2: begin
            msg_done = 1'b1;
            if ((status_q[7:4] == STATUS_NOTE_ON) && chan_match && (bus.data != 8'h00)) begin
              data_d  = note_q;
              amp_d   = vel_to_amp(bus.data[6:0]);
              valid_d = 1'b1;
            end else if (chan_match && (note_q == data_q) &&
                         ((status_q[7:4] == STATUS_NOTE_OFF) || (status_q[7:4] == STATUS_NOTE_ON))) begin
              // Note Off, or Note On with velocity 0, for the held note.
              valid_d = 1'b0;
            end
          end
          default: ;
        endcase
      end
    end

    if (msg_done) begin
      if (KEEP_STATUS) begin
        pstate_d = P_DATA1;
      end else begin
        pstate_d = P_IDLE;
        status_d = '0;
      end
    end
  end

  assign midi_data  = data_q;
  assign amplitude  = amp_q;
  assign midi_valid = valid_q;
  assign frame_err  = bus.frame_err;

endmodule

// File: doc/midi_rx_parser.md
MIDI_RX_PARSER -- requirements
Module: midi_rx_parser

Interface
REQ-001 SHALL have parameter CLK_FREQ_HZ, default 100000000, system clock frequency.
REQ-002 SHALL have parameter BAUD, default 31250, MIDI serial rate.
REQ-003 SHALL have port clk  input  1  system clock; the block uses one clock only and all flops are on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port midi_rx  input  1  serial MIDI line, idle high, asynchronous to clk.
REQ-006 SHALL have port channel  input  4  MIDI channel accepted (0-15).
REQ-007 SHALL have port midi_data  output  8  currently held note number (0-127), feeds midi_player.
REQ-008 SHALL have port midi_valid  output  1  level, high while a note is held.
REQ-009 SHALL have port amplitude  output  8  velocity of held note, {vel[6:0],vel[6]}.
REQ-010 SHALL have port frame_err  output  1  one-cycle pulse on bad stop bit.

Function
REQ-011 SHALL pass midi_rx through a 2-flop synchronizer before any use.
REQ-012 SHALL use bit period DIV = CLK_FREQ_HZ/BAUD cycles (3200 at defaults) and a baud counter wide enough for DIV.
REQ-013 SHALL use a UART FSM with states IDLE, START, DATA, STOP: falling edge starts START; the line is re-sampled at DIV/2; if it is high, the FSM returns to IDLE (glitch).
REQ-014 SHALL sample 8 data bits LSB first at the bit centres, then the stop bit; stop=1 yields a byte strobe, stop=0 pulses frame_err, drops the byte and resets the parser to P_IDLE.
REQ-015 SHALL use a parser FSM with states P_IDLE, P_DATA1, P_DATA2, fed by byte strobes.
REQ-016 SHALL treat bytes 0xF8-0xFF (real-time) as ignored, with no change to parser state or outputs.
REQ-017 SHALL treat bytes 0xF0-0xF7 as clearing the stored status and entering P_IDLE.
REQ-018 SHALL treat bytes 0x80-0xEF as storing the status and entering P_DATA1.
REQ-019 SHALL, in P_DATA1, store a data byte (bit7=0) as the note and go to P_DATA2; messages other than 0x8n/0x9n SHALL still consume their data bytes without output change (0xCn/0xDn are one data byte).
REQ-020 SHALL, in P_DATA2, complete the message on a data byte: Note On (0x9n, n==channel, vel>0) sets midi_data=note, amplitude from vel, midi_valid=1 (last-note priority).
REQ-021 SHALL treat Note Off (0x8n), or Note On with vel=0, for n==channel and note==midi_data as clearing midi_valid; midi_data and amplitude hold their values; a note that does not match SHALL be ignored.
REQ-022 SHALL update outputs exactly 1 clk after the byte strobe of the completing byte.
REQ-023 SHALL, after completing a message, return the parser to P_DATA1 when the status is retained (running status), else to P_IDLE.
REQ-024 SHALL treat a data byte in P_IDLE as dropped.
REQ-025 SHALL sample channel at message completion; a change of channel mid-message uses the new value.

Reset
REQ-026 SHALL, while rst_n=0, immediately hold midi_data=0, amplitude=0, midi_valid=0, frame_err=0, both FSMs idle, stored status cleared and the synchronizer set to 1.
REQ-027 SHALL treat a frame in progress at reset release as lost; reception restarts on the next falling edge.

Configuration
REQ-028 SHALL implement running status when macro MIDI_RUNNING_STATUS_EN is defined: the status is retained after a message per REQ-023.
REQ-029 SHALL, without MIDI_RUNNING_STATUS_EN, clear the status after each message, so data bytes without a new status are dropped.

Structure
REQ-030 SHALL place the UART and parser state enums plus the constants STATUS_NOTE_OFF=4'h8, STATUS_NOTE_ON=4'h9 and RT_MIN=8'hF8 in a shared package, midi_pkg.
REQ-031 SHALL place the serial deserializer in sub-module midi_uart_rx (byte, strobe, frame_err outputs); the parser stays in the top module.

Verification
REQ-032 SHALL cover: channel=0, send 0x90 0x3C 0x64 -> midi_data=60, amplitude=0xC9, midi_valid=1, one clk after the final strobe.
REQ-033 SHALL cover: then send 0x80 0x3C 0x00 -> midi_valid=0, midi_data stays 60; then 0x80 0x3E 0x40 -> no change.
REQ-034 SHALL cover: with MIDI_RUNNING_STATUS_EN, send 0x90 0x3C 0x64 0x3E 0x50 -> midi_data=62, amplitude=0xA1; without the macro, midi_data=60.
REQ-035 SHALL cover: channel=2, send 0x91 0x40 0x7F -> no output change; insert 0xF8 between 0x92 and 0x40 -> note 64 plays.
REQ-036 SHALL cover: a byte whose stop bit is 0 -> one frame_err pulse, the parser is in P_IDLE, and the next valid 0x90 0x3C 0x64 plays.
REQ-037 SHALL cover: a 1000-cycle low glitch on midi_rx -> no byte strobe; rst_n low mid-frame -> all outputs 0 asynchronously.
